// File: rtl/lvds_tx_pkg.sv
// Shared definitions for the LVDS transmit framer: link width, FSM states,
// default lane patterns and the lane-replication helper.
package lvds_tx_pkg;

  localparam int DB_W  = 16;
  localparam int BUS_W = DB_W * 8;

  localparam logic [7:0] TRAIN_PAT_DEF = 8'hA5;
  localparam logic [7:0] SYNC_PAT_DEF  = 8'hBC;
  localparam logic [7:0] IDLE_PAT_DEF  = 8'h00;

  typedef enum logic [1:0] {
    ST_TRAIN,
    ST_SYNC,
    ST_DATA
  } state_t;

  function automatic logic [BUS_W-1:0] rep_lane(input logic [7:0] lane_byte);
    return {DB_W{lane_byte}};
  endfunction

endpackage

// File: rtl/lvds_tx_framer_if.sv
// Upstream beat stream into the framer: valid/ready handshake carrying one
// parallel word (byte i -> lane i) and an end-of-frame marker.
interface lvds_tx_framer_if;
  import lvds_tx_pkg::*;

  logic             valid;
  logic             ready;
  logic [BUS_W-1:0] data;
  logic             last;

  modport master (output valid, data, last, input ready);
  modport slave  (input valid, data, last, output ready);

endinterface

// File: rtl/lvds_tx_beat_cnt.sv
// Training-burst beat counter: counts while enabled, flags the last beat of
// a TRAIN_LEN burst and is held at zero while cleared.
module lvds_tx_beat_cnt #(
  parameter int unsigned TRAIN_LEN = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [15:0] cnt;

  assign tc = (cnt == 16'(TRAIN_LEN - 1));

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tc ? '0 : cnt + 16'd1;
    end
  end

endmodule

// File: rtl/lvds_tx_framer.sv
// LVDS transmit framer in the parallel-word domain: link training, per-frame
// sync beats, idle fill and frame accounting ahead of the serializer.
module lvds_tx_framer
  import lvds_tx_pkg::*;
#(
  parameter int unsigned TRAIN_LEN = 256,
  parameter logic [7:0]  TRAIN_PAT = TRAIN_PAT_DEF,
  parameter logic [7:0]  SYNC_PAT  = SYNC_PAT_DEF,
  parameter logic [7:0]  IDLE_PAT  = IDLE_PAT_DEF
) (
  input  logic             clk_div,
  input  logic             rst,
  input  logic             train_req,
  lvds_tx_framer_if.slave  s,
  output logic             tx_dvld,
  output logic [BUS_W-1:0] tx_data,
  output logic             link_up,
  output logic             frm_abort,
  output logic [15:0]      frm_cnt
);

  state_t state;
  logic   frame_open;
  logic   cnt_tc;
  logic   in_train;
  logic   accept;

  assign in_train = (state == ST_TRAIN);
  assign s.ready  = (state == ST_DATA) & ~train_req;
  assign accept   = s.valid & s.ready;

  // Counter sits at zero outside TRAIN, so every burst starts from beat 0.
  lvds_tx_beat_cnt #(.TRAIN_LEN(TRAIN_LEN)) u_beat_cnt (
    .clk (clk_div),
    .rst (rst),
    .clr (~in_train),
    .en  (in_train),
    .tc  (cnt_tc)
  );

  always_ff @(posedge clk_div or posedge rst) begin
    if (rst) begin
      state      <= ST_TRAIN;
      frame_open <= 1'b0;
      tx_dvld    <= 1'b0;
      tx_data    <= rep_lane(IDLE_PAT);
      link_up    <= 1'b0;
      frm_abort  <= 1'b0;
      frm_cnt    <= '0;
    end else begin
      frm_abort <= 1'b0;
      tx_dvld   <= 1'b0;
      tx_data   <= rep_lane(IDLE_PAT);
      unique case (state)
        ST_TRAIN: begin
          tx_data <= rep_lane(TRAIN_PAT);
          if (cnt_tc) state <= ST_SYNC;
        end
        ST_SYNC: begin
          if (train_req) begin
            state   <= ST_TRAIN;
            link_up <= 1'b0;
          end else begin
            tx_data <= rep_lane(SYNC_PAT);
            state   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (train_req) begin
            state      <= ST_TRAIN;
            link_up    <= 1'b0;
            frm_abort  <= frame_open;
            frame_open <= 1'b0;
          end else begin
            // Link is declared up only once the SYNC beat is already on the wire.
            link_up <= 1'b1;
            if (accept) begin
              tx_data <= s.data;
              tx_dvld <= 1'b1;
              if (s.last) begin
                frm_cnt    <= frm_cnt + 16'd1;
                frame_open <= 1'b0;
                state      <= ST_SYNC;
              end else begin
                frame_open <= 1'b1;
              end
            end
          end
        end
        default: state <= ST_TRAIN;
      endcase
    end
  end

endmodule

// File: tb/tb_lvds_tx_framer.sv
// Directed self-checking bench for lvds_tx_framer: training, framing, back-to-back
// frames, retrain abort, ignored retrain, asynchronous reset and counter wrap.
module tb_lvds_tx_framer;
  import lvds_tx_pkg::*;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             train_req = 1'b0;
  logic             tx_dvld;
  logic [BUS_W-1:0] tx_data;
  logic             link_up;
  logic             frm_abort;
  logic [15:0]      frm_cnt;

  int errors = 0;
  int checks = 0;

  localparam logic [BUS_W-1:0] TRN = {DB_W{8'hA5}};
  localparam logic [BUS_W-1:0] SYN = {DB_W{8'hBC}};
  localparam logic [BUS_W-1:0] IDL = {DB_W{8'h00}};
  localparam logic [BUS_W-1:0] D0  = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
  localparam logic [BUS_W-1:0] D1  = 128'hFFEEDDCC_BBAA9988_77665544_33221100;
  localparam logic [BUS_W-1:0] D2  = 128'h12345678_9ABCDEF0_0FEDCBA9_87654321;
  localparam logic [BUS_W-1:0] D3  = 128'h80000000_00000000_00000000_00000001;

  lvds_tx_framer_if s_if();

  lvds_tx_framer #(.TRAIN_LEN(256)) dut (
    .clk_div   (clk),
    .rst       (rst),
    .train_req (train_req),
    .s         (s_if),
    .tx_dvld   (tx_dvld),
    .tx_data   (tx_data),
    .link_up   (link_up),
    .frm_abort (frm_abort),
    .frm_cnt   (frm_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [BUS_W-1:0] d, input logic l);
    s_if.valid = v;
    s_if.data  = d;
    s_if.last  = l;
  endtask

  // 256 training beats, one SYNC beat, then idle with link up.
  task automatic train_and_sync(input int pulse_at, input string tag);
    int bad;
    bad = 0;
    for (int i = 1; i <= 256; i++) begin
      if (i == pulse_at) train_req = 1'b1;
      step();
      train_req = 1'b0;
      if (tx_data !== TRN || tx_dvld !== 1'b0 || link_up !== 1'b0 || frm_abort !== 1'b0)
        bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL %s train_beats: %0d bad beats of 256, required 0", tag, bad);
    end
    step();
    checks++;
    if (tx_data !== SYN || tx_dvld !== 1'b0 || link_up !== 1'b0) begin
      errors++;
      $display("FAIL %s sync_beat: data=%h dvld=%b link_up=%b, required data=%h dvld=0 link_up=0",
               tag, tx_data, tx_dvld, link_up, SYN);
    end
    step();
    checks++;
    if (tx_data !== IDL || tx_dvld !== 1'b0 || link_up !== 1'b1 || s_if.ready !== 1'b1) begin
      errors++;
      $display("FAIL %s post_sync: data=%h dvld=%b link_up=%b ready=%b, required idle/0/1/1",
               tag, tx_data, tx_dvld, link_up, s_if.ready);
    end
  endtask

  task automatic test_reset();
    drive(1'b0, '0, 1'b0);
    train_req = 1'b0;
    rst = 1'b1;
    step();
    step();
    checks++;
    if (tx_data !== IDL || tx_dvld !== 1'b0 || link_up !== 1'b0 || frm_abort !== 1'b0 ||
        frm_cnt !== 16'h0000 || s_if.ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: data=%h dvld=%b link=%b abort=%b cnt=%h ready=%b, required idle/0/0/0/0000/0",
               tx_data, tx_dvld, link_up, frm_abort, frm_cnt, s_if.ready);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_link_up();
    train_and_sync(0, "link_up");
  endtask

  task automatic test_frame_gap();
    logic             v_seq [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [BUS_W-1:0] d_seq [6] = '{D0, D1, D3, D2, D3, D1};
    logic             l_seq [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [BUS_W-1:0] e_dat [6] = '{D0, D1, IDL, D2, D3, SYN};
    logic             e_dv  [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 6; i++) begin
      drive(v_seq[i], d_seq[i], l_seq[i]);
      step();
      checks++;
      if (tx_data !== e_dat[i] || tx_dvld !== e_dv[i]) begin
        errors++;
        $display("FAIL frame_gap beat%0d: data=%h dvld=%b, required data=%h dvld=%b",
                 i, tx_data, tx_dvld, e_dat[i], e_dv[i]);
      end
    end
    checks++;
    if (frm_cnt !== 16'd1) begin
      errors++;
      $display("FAIL frame_gap frm_cnt: got %0d, required 1", frm_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic             rdy_seq [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [BUS_W-1:0] d_seq   [5] = '{D2, D3, D0, D0, D1};
    logic             l_seq   [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [BUS_W-1:0] e_dat   [5] = '{D2, D3, SYN, D0, D1};
    logic             e_dv    [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, d_seq[i], l_seq[i]);
      #1;
      checks++;
      if (s_if.ready !== rdy_seq[i]) begin
        errors++;
        $display("FAIL b2b ready%0d: got %b, required %b", i, s_if.ready, rdy_seq[i]);
      end
      step();
      checks++;
      if (tx_data !== e_dat[i] || tx_dvld !== e_dv[i]) begin
        errors++;
        $display("FAIL b2b beat%0d: data=%h dvld=%b, required data=%h dvld=%b",
                 i, tx_data, tx_dvld, e_dat[i], e_dv[i]);
      end
    end
    drive(1'b0, '0, 1'b0);
    checks++;
    if (frm_cnt !== 16'd3) begin
      errors++;
      $display("FAIL b2b frm_cnt: got %0d, required 3", frm_cnt);
    end
    step();
    checks++;
    if (tx_data !== SYN || tx_dvld !== 1'b0) begin
      errors++;
      $display("FAIL b2b trailing_sync: data=%h dvld=%b, required %h dvld=0", tx_data, tx_dvld, SYN);
    end
    step();
  endtask

  task automatic test_retrain_abort();
    drive(1'b1, D0, 1'b0);
    step();
    drive(1'b1, D1, 1'b0);
    train_req = 1'b1;
    #1;
    checks++;
    if (s_if.ready !== 1'b0) begin
      errors++;
      $display("FAIL abort ready_during_req: got %b, required 0", s_if.ready);
    end
    step();
    train_req = 1'b0;
    drive(1'b0, '0, 1'b0);
    checks++;
    if (frm_abort !== 1'b1 || link_up !== 1'b0 || tx_dvld !== 1'b0 || tx_data !== IDL) begin
      errors++;
      $display("FAIL abort pulse: abort=%b link=%b dvld=%b data=%h, required 1/0/0/idle",
               frm_abort, link_up, tx_dvld, tx_data);
    end
    train_and_sync(0, "abort");
    checks++;
    if (frm_cnt !== 16'd3) begin
      errors++;
      $display("FAIL abort frm_cnt: got %0d, required 3", frm_cnt);
    end
  endtask

  task automatic test_ignored_req_and_reset();
    int bad;
    train_req = 1'b1;
    step();
    train_req = 1'b0;
    checks++;
    if (frm_abort !== 1'b0 || link_up !== 1'b0) begin
      errors++;
      $display("FAIL idle_retrain: abort=%b link=%b, required 0/0", frm_abort, link_up);
    end
    train_and_sync(100, "ignored_req");

    drive(1'b1, D2, 1'b0);
    step();
    drive(1'b0, '0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (tx_data !== IDL || tx_dvld !== 1'b0 || link_up !== 1'b0 || frm_abort !== 1'b0 ||
        frm_cnt !== 16'h0000 || s_if.ready !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: data=%h dvld=%b link=%b abort=%b cnt=%h ready=%b, required idle/0/0/0/0000/0",
               tx_data, tx_dvld, link_up, frm_abort, frm_cnt, s_if.ready);
    end
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (frm_abort !== 1'b0 || tx_data !== IDL) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL reset_hold: %0d bad cycles, required 0", bad);
    end
    @(negedge clk);
    rst = 1'b0;
    train_and_sync(0, "after_reset");
  endtask

  task automatic test_cnt_wrap();
    force dut.frm_cnt = 16'hFFFF;
    step();
    release dut.frm_cnt;
    step();
    checks++;
    if (frm_cnt !== 16'hFFFF) begin
      errors++;
      $display("FAIL wrap preload: got %h, required ffff", frm_cnt);
    end
    drive(1'b1, D3, 1'b1);
    step();
    drive(1'b0, '0, 1'b0);
    checks++;
    if (frm_cnt !== 16'h0000 || tx_dvld !== 1'b1 || tx_data !== D3) begin
      errors++;
      $display("FAIL wrap count: cnt=%h dvld=%b data=%h, required 0000/1/%h",
               frm_cnt, tx_dvld, tx_data, D3);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_link_up();
    test_frame_gap();
    test_back_to_back();
    test_retrain_abort();
    test_ignored_req_and_reset();
    test_cnt_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
